// File: rtl/sm83_edge_delay_probe.sv
// Edge-to-response delay probe: counts clock ticks from a stimulus edge until the
// cell output reaches its expected level, keeping rise and fall results separately.
module sm83_edge_delay_probe #(
   parameter int W         = 8,
   parameter int MAX_TICKS = 200,
   parameter bit INVERT    = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         arm,
   input  logic         stim,
   input  logic         resp,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic         overlap,
   output logic [W-1:0] rise_ticks,
   output logic [W-1:0] fall_ticks,
   output logic [W-1:0] n_meas
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEASURE, S_DONE} state_t;

   localparam logic [W-1:0] MAX_CNT = W'(MAX_TICKS);

   state_t       state, state_d;
   logic         stim_q;
   logic         exp_q, exp_d;
   logic [W-1:0] cnt, cnt_d;
   logic         take_edge;
   logic         rec, rec_pol;
   logic [W-1:0] rec_val;
   logic         timeout_d, overlap_d;
   logic         edge_det, exp_lvl;

   assign edge_det = stim ^ stim_q;
   assign exp_lvl  = stim ^ INVERT;

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      exp_d     = exp_q;
      take_edge = 1'b0;
      rec       = 1'b0;
      rec_pol   = exp_q;
      rec_val   = '0;
      timeout_d = 1'b0;
      overlap_d = 1'b0;
      case (state)
         S_IDLE: begin
            if (arm) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!arm) state_d = S_IDLE;
            else if (edge_det) take_edge = 1'b1;
         end
         S_MEASURE: begin
            if (edge_det) begin
               overlap_d = 1'b1;
               take_edge = 1'b1;
            end else if (resp == exp_q) begin
               rec     = 1'b1;
               rec_val = cnt;
               state_d = S_DONE;
            end else if (cnt == MAX_CNT) begin
               timeout_d = 1'b1;
               state_d   = arm ? S_WAIT : S_IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_d = arm ? S_WAIT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A new edge either resolves immediately (zero delay) or starts a fresh count.
      if (take_edge) begin
         exp_d = exp_lvl;
         if (resp == exp_lvl) begin
            rec     = 1'b1;
            rec_pol = exp_lvl;
            rec_val = '0;
            state_d = S_DONE;
         end else begin
            cnt_d   = W'(1);
            state_d = S_MEASURE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         exp_q      <= 1'b0;
         stim_q     <= 1'b0;
         timeout    <= 1'b0;
         overlap    <= 1'b0;
         rise_ticks <= '0;
         fall_ticks <= '0;
         n_meas     <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         exp_q   <= exp_d;
         stim_q  <= stim;
         timeout <= timeout_d;
         overlap <= overlap_d;
         if (rec) begin
            if (rec_pol) rise_ticks <= rec_val;
            else         fall_ticks <= rec_val;
            n_meas <= n_meas + 1'b1;
         end
      end
   end

   assign busy = (state == S_MEASURE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_sm83_edge_delay_probe.sv
// Directed bench for sm83_edge_delay_probe: scoreboard of expected delays popped on done.
module tb_sm83_edge_delay_probe;

   localparam int W    = 8;
   localparam int MAXT = 200;

   logic clk = 1'b0;
   logic reset;
   logic arm0, stim0, resp0;
   logic busy0, done0, timeout0, overlap0;
   logic [W-1:0] rise0, fall0, nmeas0;
   logic arm1, stim1, resp1;
   logic busy1, done1, timeout1, overlap1;
   logic [W-1:0] rise1, fall1, nmeas1;

   always #5 clk = ~clk;

   sm83_edge_delay_probe #(.W(W), .MAX_TICKS(MAXT), .INVERT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .arm(arm0), .stim(stim0), .resp(resp0),
      .busy(busy0), .done(done0), .timeout(timeout0), .overlap(overlap0),
      .rise_ticks(rise0), .fall_ticks(fall0), .n_meas(nmeas0)
   );

   sm83_edge_delay_probe #(.W(W), .MAX_TICKS(MAXT), .INVERT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .arm(arm1), .stim(stim1), .resp(resp1),
      .busy(busy1), .done(done1), .timeout(timeout1), .overlap(overlap1),
      .rise_ticks(rise1), .fall_ticks(fall1), .n_meas(nmeas1)
   );

   typedef struct {
      logic         pol;
      logic [W-1:0] ticks;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] model_n    = '0;
   logic [W-1:0] last_rise  = '0;
   logic [W-1:0] last_fall  = '0;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Drive one non-inverting measurement on dut0 with response d ticks after the edge.
   task automatic do_meas(input logic s, input int d);
      exp_t e;
      e.pol   = s;
      e.ticks = W'(d);
      sb.push_back(e);
      stim0 = s;
      if (d == 0) resp0 = s;
      tick();
      for (int i = 1; i < d; i++) tick();
      if (d > 0) begin
         resp0 = s;
         tick();
      end
   endtask

   task automatic check_done(input string tag);
      exp_t e;
      int   k;
      k = 0;
      while (done0 !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      chk({tag, "_done"}, done0, 1);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb.pop_front();
         model_n = model_n + 1'b1;
         if (e.pol) begin
            last_rise = e.ticks;
            chk({tag, "_rise"}, rise0, e.ticks);
         end else begin
            last_fall = e.ticks;
            chk({tag, "_fall"}, fall0, e.ticks);
         end
         chk({tag, "_nmeas"}, nmeas0, model_n);
      end
      tick();
      chk({tag, "_done_width"}, done0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      reset = 1'b1;
      arm0 = 1'b0; stim0 = 1'b0; resp0 = 1'b0;
      arm1 = 1'b0; stim1 = 1'b0; resp1 = 1'b1;
      tick();
      tick();
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_timeout", timeout0, 0);
      chk("rst_overlap", overlap0, 0);
      chk("rst_rise", rise0, 0);
      chk("rst_fall", fall0, 0);
      chk("rst_nmeas", nmeas0, 0);
      chk("rst_busy1", busy1, 0);

      // Basic rise with 3-tick delay
      reset = 1'b0;
      arm0  = 1'b1;
      tick();
      do_meas(1'b1, 3);
      chk("rise3_fall_untouched", fall0, 0);
      check_done("rise3");

      // Inverting path: same-edge responses record zero
      arm1 = 1'b1;
      tick();
      stim1 = 1'b1; resp1 = 1'b0;
      tick();
      chk("inv_settle_done", done1, 1);
      chk("inv_settle_nmeas", nmeas1, 1);
      tick();
      stim1 = 1'b0; resp1 = 1'b1;
      tick();
      chk("inv_zero_done", done1, 1);
      chk("inv_zero_rise", rise1, 0);
      chk("inv_zero_nmeas", nmeas1, 2);
      tick();
      chk("inv_done_width", done1, 0);

      // Timeout: no response for MAXT ticks
      stim0 = 1'b0;
      tick();
      chk("to_busy", busy0, 1);
      acc = 1'b0;
      for (int k = 1; k < MAXT; k++) begin
         tick();
         acc = acc | timeout0 | done0;
      end
      chk("to_early", acc, 0);
      tick();
      chk("to_pulse", timeout0, 1);
      chk("to_busy_drop", busy0, 0);
      chk("to_done", done0, 0);
      chk("to_rise", rise0, last_rise);
      chk("to_fall", fall0, last_fall);
      chk("to_nmeas", nmeas0, model_n);
      tick();
      chk("to_width", timeout0, 0);

      // Overlap: second edge aborts the first measurement
      resp0 = 1'b0;
      tick();
      stim0 = 1'b1;
      tick();
      tick();
      begin
         exp_t e;
         e.pol = 1'b0; e.ticks = W'(4);
         sb.push_back(e);
      end
      stim0 = 1'b0; resp0 = 1'b1;
      tick();
      chk("ovl_pulse", overlap0, 1);
      chk("ovl_busy", busy0, 1);
      tick();
      chk("ovl_width", overlap0, 0);
      tick();
      tick();
      resp0 = 1'b0;
      tick();
      check_done("ovl");
      chk("ovl_rise_kept", rise0, last_rise);

      // Counter wrap after 256 completed measurements
      for (int i = 0; i < 256 - 2; i++) begin
         do_meas(~stim0, (i % 4) + 1);
         check_done("wrap");
      end
      chk("wrap_nmeas_zero", nmeas0, 0);

      // Reset in the middle of a measurement
      stim0 = ~stim0;
      tick();
      tick();
      chk("mid_busy", busy0, 1);
      reset = 1'b1; stim0 = 1'b0; resp0 = 1'b0;
      tick();
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_rise", rise0, 0);
      chk("mid_rst_fall", fall0, 0);
      chk("mid_rst_nmeas", nmeas0, 0);
      reset = 1'b0; arm0 = 1'b0;
      sb.delete();
      model_n = '0; last_rise = '0; last_fall = '0;
      tick();

      // Disarmed: edges ignored
      acc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stim0 = ~stim0;
         tick();
         acc = acc | done0 | timeout0 | overlap0 | busy0;
         tick();
         acc = acc | done0 | timeout0 | overlap0 | busy0;
      end
      chk("disarm_quiet", acc, 0);
      chk("disarm_nmeas", nmeas0, 0);

      // Dropping arm mid-measurement still completes, then returns to IDLE
      arm0 = 1'b1;
      tick();
      begin
         exp_t e;
         e.pol = 1'b1; e.ticks = W'(3);
         sb.push_back(e);
      end
      stim0 = 1'b1;
      tick();
      arm0 = 1'b0;
      tick();
      tick();
      resp0 = 1'b1;
      tick();
      check_done("drop");
      chk("drop_busy", busy0, 0);
      stim0 = 1'b0;
      tick();
      tick();
      tick();
      chk("drop_idle_busy", busy0, 0);
      chk("drop_idle_nmeas", nmeas0, model_n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sm83_edge_delay_probe.md
# sm83_edge_delay_probe

Simulation-side probe that measures the propagation delay of an sm83 gate-level cell, in clock ticks. It watches the stimulus driven into one cell input and the response on the cell output. After each stimulus edge it counts ticks until the output reaches its expected level, reporting rise and fall delays separately. It is the receiving end of the cell timing model: cells produce delayed edges, this block observes and quantifies them for characterization benches.

## Interface
Parameters:
- W, 8: width of tick counters and result registers.
- MAX_TICKS, 200: timeout threshold. Must be ≥1 and ≤ 2^W−1.
- INVERT, 0: 1 if the measured path is inverting, so the expected response level is !stim. 0 if non-inverting.

Ports:
- clk  input  1  probe sampling clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  enables measurement; level-sensitive.
- stim  input  1  stimulus net driven into the cell.
- resp  input  1  cell output net under measurement.
- busy  output  1  high while in MEASURE.
- done  output  1  one-cycle pulse when a measurement completes (not on timeout).
- timeout  output  1  one-cycle pulse when MAX_TICKS elapsed without response.
- overlap  output  1  one-cycle pulse when a new stim edge aborts a running measurement.
- rise_ticks  output  W  last measured delay for a resp rising result.
- fall_ticks  output  W  last measured delay for a resp falling result.
- n_meas  output  W  count of completed measurements; wraps modulo 2^W.

## Operation
- Registers: stim_q (previous stim sample), exp (expected resp level), cnt (W bits), state.
- Stim edge = (stim != stim_q) at a posedge. stim_q <= stim on every posedge, in every state.
- Expected level on edge = stim ^ INVERT.
- States:
  - IDLE: if arm is high, go to WAIT. Edges seen while in IDLE are ignored.
  - WAIT: if arm is low, go to IDLE. On a stim edge:
    - if resp == expected, record 0 and go to DONE;
    - otherwise set exp, set cnt=1, go to MEASURE.
  - MEASURE (evaluated in priority order):
    1. Stim edge: pulse overlap, then handle it exactly as a WAIT edge (restart or zero-record).
    2. resp == exp: record cnt.
    3. cnt == MAX_TICKS: pulse timeout, go to WAIT or IDLE per arm. No result register changes.
    4. Otherwise: cnt++.
    - arm is ignored while in MEASURE; the measurement always finishes, times out, or is overlapped.
  - DONE: single-cycle state that asserts done, then goes to WAIT if arm is high, else IDLE.
- Record:
  - if exp == 1, rise_ticks <= value; else fall_ticks <= value.
  - n_meas++.
  - state <= DONE.
- Result registers hold their value until overwritten by the next record of the same polarity.

## Timing
- Reset (synchronous, dominates all other inputs): state=IDLE, cnt=0, exp=0, stim_q=0, rise_ticks=0, fall_ticks=0, n_meas=0. All outputs low/zero from the first posedge with reset high.
- Because stim_q resets to 0, a stim held at 1 through reset release produces an edge on the first armed posedge in WAIT. Benches hold stim=0 during reset.
- Delay definition: number of posedges from the edge-detect posedge (exclusive) to the posedge at which resp == exp (inclusive). Same-edge response = 0.
- done, n_meas, rise_ticks/fall_ticks: registered outputs, all visible in the cycle after the record posedge. done is high for exactly one cycle.
- timeout and overlap: registered, one cycle wide, asserted in the cycle after the detecting posedge.
- busy == (state == MEASURE), registered.
- Back-to-back: after DONE, the earliest next edge accepted is at the posedge after DONE. An edge arriving during the DONE cycle is lost; benches space edges by ≥2 cycles.
- Arming latency: arm rising in IDLE reaches WAIT after 1 posedge, so an edge on that same posedge is not measured.

## Test plan
- Reset, then arm=1. Stim 0→1 with INVERT=0; resp rises 3 cycles later → rise_ticks=3, done pulse 1 cycle, n_meas=1, fall_ticks=0.
- INVERT=1. Stim 1→0 (after settle); resp rises on the same posedge as the stim edge is sampled → rise_ticks=0, done next cycle.
- Stim edge, resp never toggles → timeout pulse exactly MAX_TICKS posedges after the edge, busy drops, rise_ticks/fall_ticks/n_meas unchanged.
- Stim 0→1, then 1→0 two cycles later with no response; resp falls 4 cycles after the second edge → overlap pulse once, fall_ticks=4, rise_ticks unchanged.
- Run 256 successful measurements → n_meas wraps to 0; assert reset mid-MEASURE → next cycle busy=0 and all results 0.
- arm=0 with stim toggling → no done/timeout/overlap, n_meas stays 0. Drop arm mid-MEASURE → measurement still completes, then state returns to IDLE.
